enemy_wave_controller: RTL

//  Sequences up to N_ENEMY enemy instances for one game round: staggered start pulses, kill/death tracking, round outcome.

---
 rtl/enemy_wave_if.sv | 31 +++
 rtl/enemy_wave_controller.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/enemy_wave_if.sv
// enemy_wave_if
//   Bundles the game-side signals of enemy_wave_controller.
//   master : game top / bench side (drives round control and per-enemy status, reads results)
//   slave  : enemy_wave_controller side
//   Signals: game_start, enemy_alive, death_in, enemy_on_in, enemy_rgb_in (inputs to controller);
//            enemy_start, enemy_on, rgb_out, kill_count, level_clear, game_over (outputs).
interface enemy_wave_if #(
  parameter int N_ENEMY = 4
);
  logic                    game_start;
  logic [N_ENEMY-1:0]      enemy_alive;
  logic [N_ENEMY-1:0]      death_in;
  logic [N_ENEMY-1:0]      enemy_on_in;
  logic [12*N_ENEMY-1:0]   enemy_rgb_in;
  logic [N_ENEMY-1:0]      enemy_start;
  logic                    enemy_on;
  logic [11:0]             rgb_out;
  logic [3:0]              kill_count;
  logic                    level_clear;
  logic                    game_over;

  modport master (
    output game_start, enemy_alive, death_in, enemy_on_in, enemy_rgb_in,
    input  enemy_start, enemy_on, rgb_out, kill_count, level_clear, game_over
  );

  modport slave (
    input  game_start, enemy_alive, death_in, enemy_on_in, enemy_rgb_in,
    output enemy_start, enemy_on, rgb_out, kill_count, level_clear, game_over
  );
endinterface

// File: rtl/enemy_wave_controller.sv
// enemy_wave_controller
//   Sequences N_ENEMY enemies for one round: staggered one-cycle start pulses,
//   kill counting, and the sticky round outcome (level_clear / game_over).
//   Also merges the per-enemy sprite pixels into a single enemy_on / rgb_out pair,
//   lowest enemy index wins.
// Ports
//   clk    : system clock
//   reset  : asynchronous, active-high game reset
//   bus    : enemy_wave_if.slave (round control, per-enemy status, pixel inputs, results)
// Optional build macro
//   ENEMY_PIXEL_ALIGN_EN : registers the hit vector one clock ahead of the pixel mux so
//                          enemy_on lines up with a synchronous sprite ROM (1 clk latency).
//
// state | meaning
// IDLE  | waiting for game_start
// SPAWN | issuing start pulses every SPAWN_DELAY clocks
// RUN   | all enemies started, waiting for outcome
// CLEAR | all enemies killed, bomberman alive (terminal until reset)
// OVER  | bomberman killed by a started enemy (terminal until reset)
module enemy_wave_controller #(
  parameter int N_ENEMY     = 4,
  parameter int SPAWN_DELAY = 50_000_000,
  parameter int CNT_W       = 26
) (
  input  logic       clk,
  input  logic       reset,
  enemy_wave_if.slave bus
);

  localparam int IDX_W = (N_ENEMY > 1) ? $clog2(N_ENEMY) : 1;

  typedef enum logic [2:0] {IDLE, SPAWN, RUN, CLEAR, OVER} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [IDX_W-1:0]    idx_q;
  logic [N_ENEMY-1:0]  started_q;
  logic [N_ENEMY-1:0]  start_q;
  logic [3:0]          kill_q;

  logic                death_hit;
  logic                all_killed;
  logic                spawn_tick;
  logic                last_idx;
  logic [N_ENEMY-1:0]  idx_onehot;
  logic [3:0]          kill_pop;

  logic [N_ENEMY-1:0]  hit;
  logic [N_ENEMY-1:0]  hit_m;
  logic [11:0]         rgb_c;

  assign death_hit  = |(bus.death_in & started_q);
  assign all_killed = (&started_q) && (bus.enemy_alive == '0);
  assign spawn_tick = (cnt_q == CNT_W'(SPAWN_DELAY - 1));
  assign last_idx   = (idx_q == IDX_W'(N_ENEMY - 1));
  assign idx_onehot = N_ENEMY'(1) << idx_q;

  always_comb begin
    kill_pop = '0;
    for (int i = 0; i < N_ENEMY; i++) begin
      kill_pop = kill_pop + 4'(started_q[i] & ~bus.enemy_alive[i]);
    end
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next state; death outranks a simultaneous last kill
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.game_start) state_d = (N_ENEMY == 1) ? RUN : SPAWN;
      end
      SPAWN: begin
        if (death_hit)                 state_d = OVER;
        else if (all_killed)           state_d = CLEAR;
        else if (spawn_tick && last_idx) state_d = RUN;
      end
      RUN: begin
        if (death_hit)       state_d = OVER;
        else if (all_killed) state_d = CLEAR;
      end
      default: state_d = state_q;
    endcase
  end

  // spawn counter, start pulses, started mask, kill counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      started_q <= '0;
      start_q   <= '0;
      kill_q    <= '0;
    end else begin
      start_q <= '0;
      case (state_q)
        IDLE: begin
          if (bus.game_start) begin
            start_q   <= N_ENEMY'(1);
            started_q <= N_ENEMY'(1);
            idx_q     <= IDX_W'(1);
            cnt_q     <= '0;
          end
        end
        SPAWN: begin
          kill_q <= kill_pop;
          // a round ended by death stops issuing further pulses
          if (!death_hit) begin
            if (spawn_tick) begin
              start_q   <= idx_onehot;
              started_q <= started_q | idx_onehot;
              idx_q     <= idx_q + IDX_W'(1);
              cnt_q     <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        RUN: kill_q <= kill_pop;
        default: ;
      endcase
    end
  end

  assign hit = bus.enemy_on_in & bus.enemy_alive & started_q;

`ifdef ENEMY_PIXEL_ALIGN_EN
  logic [N_ENEMY-1:0] hit_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) hit_q <= '0;
    else       hit_q <= hit;
  end
  assign hit_m = hit_q;
`else
  assign hit_m = hit;
`endif

  // lowest index wins: scan from the top so lower hits overwrite
  always_comb begin
    rgb_c = 12'h000;
    for (int i = N_ENEMY - 1; i >= 0; i--) begin
      if (hit_m[i]) rgb_c = bus.enemy_rgb_in[12*i +: 12];
    end
  end

  // outputs
  always_comb begin
    bus.enemy_start = start_q;
    bus.kill_count  = kill_q;
    bus.level_clear = (state_q == CLEAR);
    bus.game_over   = (state_q == OVER);
    bus.enemy_on    = |hit_m;
    bus.rgb_out     = rgb_c;
  end

endmodule
